// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO writeback.
// One request is accepted at a time. A multiply waits MUL_LAT cycles before its
// result is ready. A divide uses a 1-bit/cycle restoring divider. The block
// holds the pipeline via stallreq while busy, then pulses the HI/LO write.
// Optional feature: define MULDIV_EARLY_EXIT_EN to finish a divide in one cycle
// when |dividend| < |divisor|.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              stallreq,
  output logic              busy,
  output logic              done,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              div_by_zero
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   mag_b, rem, quo;
  logic [2*DATA_W-1:0] prod;
  logic                neg_q, neg_r, dbz_r;

  logic                accept, is_div, is_signed, b_zero, early;
  logic                mul_last, div_last;
  logic [DATA_W-1:0]   abs_a, abs_b, rem_nxt, quo_nxt;
  logic [2*DATA_W-1:0] ext_a, ext_b;
  logic [DATA_W:0]     rem_sh, rem_diff;

  assign is_div    = op[1];
  assign is_signed = ~op[0];
  // rst is included so stallreq stays low while reset is held
  assign accept    = (state == S_IDLE) & start & ~flush & ~rst;
  assign b_zero    = (src_b == '0);
  assign abs_a     = (is_signed & src_a[DATA_W-1]) ? -src_a : src_a;
  assign abs_b     = (is_signed & src_b[DATA_W-1]) ? -src_b : src_b;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // Sign- or zero-extend to 64 bits so one truncated multiply serves both forms
  assign ext_a = is_signed ? {{DATA_W{src_a[DATA_W-1]}}, src_a} : {{DATA_W{1'b0}}, src_a};
  assign ext_b = is_signed ? {{DATA_W{src_b[DATA_W-1]}}, src_b} : {{DATA_W{1'b0}}, src_b};

  // Restoring divider step; quo doubles as the dividend shift register.
  // Bit DATA_W of the 33-bit difference is the borrow (rem_sh < |b|).
  assign rem_sh   = {rem, quo[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, mag_b};
  assign rem_nxt  = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
  assign quo_nxt  = {quo[DATA_W-2:0], ~rem_diff[DATA_W]};

  assign mul_last = (state == S_MUL) & (cnt == CW'(MUL_LAT - 1));
  assign div_last = (state == S_DIV) & (cnt == CW'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (!is_div)              state_nxt = S_MUL;
          else if (b_zero || early) state_nxt = S_DONE;
          else                      state_nxt = S_DIV;
        end
        S_MUL:  if (mul_last) state_nxt = S_DONE;
        S_DIV:  if (div_last) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs; write pulse is suppressed by a flush in DONE
  always_comb begin
    stallreq    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    div_by_zero = 1'b0;
    busy        = (state != S_IDLE);
    stallreq    = accept | (((state == S_MUL) | (state == S_DIV)) & ~flush);
    done        = (state == S_DONE) & ~flush;
    hi_we       = done;
    lo_we       = done;
    div_by_zero = done & dbz_r;
  end

  // Datapath: operand capture, divider iteration and HI/LO result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mag_b    <= '0;
      rem      <= '0;
      quo      <= '0;
      prod     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz_r    <= 1'b0;
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt   <= '0;
          dbz_r <= is_div & b_zero;
          if (!is_div) begin
            prod <= ext_a * ext_b;
          end else begin
            mag_b <= abs_b;
            quo   <= abs_a;
            rem   <= '0;
            neg_q <= is_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            neg_r <= is_signed & src_a[DATA_W-1];
            // Short-circuit divides resolve here, HI is simply the raw dividend
            if (b_zero || early) begin
              hi_wdata <= src_a;
              lo_wdata <= b_zero ? '1 : '0;
            end
          end
        end
        S_MUL: begin
          cnt <= cnt + CW'(1);
          if (mul_last && !flush) {hi_wdata, lo_wdata} <= prod;
        end
        S_DIV: begin
          cnt <= cnt + CW'(1);
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (div_last && !flush) begin
            lo_wdata <= neg_q ? -quo_nxt : quo_nxt;
            hi_wdata <= neg_r ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver pushes expected results computed
// with plain 64-bit arithmetic, and a negedge monitor pops them on each done pulse.
// Honors MULDIV_EARLY_EXIT_EN the same way the design does.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, done, hi_we, lo_we, div_by_zero;
  logic [31:0] hi_wdata, lo_wdata;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .stallreq(stallreq), .busy(busy),
    .done(done), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic results and done latency in cycles after T
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz, output int lat);
    longint          sa, sb_, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    dbz = 1'b0;
    hi = '0;
    lo = '0;
    if (o[1] == 1'b0) begin
      lat = MUL_LAT + 1;
      if (o[0] == 1'b0) begin
        p = sa * sb_;
        hi = p[63:32];
        lo = p[31:0];
      end else begin
        up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
      end
    end else if (b == 32'd0) begin
      lat = 1;
      dbz = 1'b1;
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      lat = 33;
      if (o[0] == 1'b0) begin
        q = sa / sb_;
        r = sa % sb_;
`ifdef MULDIV_EARLY_EXIT_EN
        if ((sa < 0 ? -sa : sa) < (sb_ < 0 ? -sb_ : sb_)) lat = 1;
`endif
      end else begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
`ifdef MULDIV_EARLY_EXIT_EN
        if (ua < ub) lat = 1;
`endif
      end
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (done || hi_we || lo_we)
      chk("we_eq_done", {62'd0, hi_we, lo_we}, {62'd0, done, done});
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("hi_wdata", {32'd0, hi_wdata}, {32'd0, e.hi});
        chk("lo_wdata", {32'd0, lo_wdata}, {32'd0, e.lo});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
        chk("stall_in_done", {62'd0, stallreq, busy}, {62'd0, 1'b0, 1'b1});
      end
    end else if (div_by_zero) begin
      chk("dbz_without_done", {63'd0, div_by_zero}, 64'd0);
    end
  end

  // Issue one op at posedge+1 (IDLE). Garbage starts while MUL/DIV must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    model(o, a, b, e.hi, e.lo, e.dbz, lat);
    start = 1'b1; op = o; src_a = a; src_b = b;
    e.cyc = cyc + lat;
    sb.push_back(e);
    #3 chk("stall_at_T", {63'd0, stallreq}, 64'd1);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (i < lat) begin
        start = 1'($urandom_range(0, 1)); op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        #3 chk("stall_busy", {63'd0, stallreq}, 64'd1);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("idle_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int          t0;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {51'd0, stallreq, busy, done, hi_we, lo_we, div_by_zero, 7'd0},
        64'd0);
    chk("reset_data", {hi_wdata, lo_wdata}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b00, 32'hFFFF_FFFF, 32'd5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b11, 32'd3, 32'd10);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd5, 32'hFFFF_FFFD);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

    // Flush mid-divide: no write, stallreq drops that cycle, next start accepted
    start = 1'b1; op = 2'b11; src_a = 32'hFFFF_0000; src_b = 32'd3;
    t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    #3 chk("flush_stall", {62'd0, stallreq, done}, 64'd0);
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_idle", {63'd0, busy}, 64'd0);
    run_op(2'b11, 32'd100, 32'd7);

    // Flush in DONE suppresses the write
    start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd0;
    @(posedge clk); #1; start = 1'b0; flush = 1'b1;
    #3 chk("flush_done_we", {61'd0, done, hi_we, lo_we}, 64'd0);
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_done_idle", {63'd0, busy}, 64'd0);

    // Flush together with start in IDLE drops the start
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd4; src_b = 32'd4;
    #3 chk("flush_start_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", {63'd0, busy}, 64'd0);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      o = 2'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'($urandom_range(0, 50));
        3: begin a = 32'($urandom_range(0, 9)); b = 32'hFFFF_FFF0; end
        default: ;
      endcase
      run_op(o, a, b);
    end

    // Async reset mid-divide clears outputs at once
    start = 1'b1; op = 2'b11; src_a = 32'hFFFF_FFFF; src_b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {58'd0, stallreq, busy, done, hi_we, lo_we, div_by_zero}, 64'd0);
    chk("rst_mid_data", {hi_wdata, lo_wdata}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    run_op(2'b01, 32'd7, 32'd6);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
